// File: rtl/channel_select_mux_pkg.sv
// Shared constants for the channel-select datapath blocks.
// Selection-mode encodings are reused by later datapath stages.
package channel_select_mux_pkg;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_RR   = 1'b1;

endpackage

// File: rtl/channel_select_mux_rr_arbiter.sv
// Round-robin arbiter: finds the first requesting channel at or after ptr,
// wrapping modulo CHANNELS, and reports it as one-hot, index and any-request.
module channel_select_mux_rr_arbiter #(
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [CHANNELS-1:0] gnt_c,
  output logic [SEL_W-1:0]    idx_c,
  output logic                any_c
);

  // Scan from the farthest offset down so the closest requester to ptr wins last.
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (req[SEL_W'(ptr + SEL_W'(k))]) begin
        idx_c = SEL_W'(ptr + SEL_W'(k));
        any_c = 1'b1;
      end
    end
    gnt_c[idx_c] = any_c;
  end

endmodule

// File: rtl/channel_select_mux.sv
// Registered N-channel mux with per-channel valid/ready, addressed or
// round-robin selection, and a single output register stage.
module channel_select_mux
  import channel_select_mux_pkg::*;
#(
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mode,
  input  logic [SEL_W-1:0]             address,
  input  logic [CHANNELS*WIDTH-1:0]    in_data,
  input  logic [CHANNELS-1:0]          in_valid,
  output logic [CHANNELS-1:0]          in_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [SEL_W-1:0]             out_channel,
  output logic                         out_valid,
  input  logic                         out_ready
);

  logic [WIDTH-1:0]    out_data_q,    out_data_d;
  logic [SEL_W-1:0]    out_channel_q, out_channel_d;
  logic                out_valid_q,   out_valid_d;
  logic [SEL_W-1:0]    rr_ptr_q,      rr_ptr_d;

  logic [CHANNELS-1:0] arb_gnt;
  logic [SEL_W-1:0]    arb_idx;
  logic                arb_any;

  logic                load_en;
  logic                grant;
  logic                xfer;
  logic [SEL_W-1:0]    cand;
  logic [CHANNELS-1:0] cand_oh;
  logic [WIDTH-1:0]    sel_data;

  channel_select_mux_rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_rr_arbiter (
    .req   (in_valid),
    .ptr   (rr_ptr_q),
    .gnt_c (arb_gnt),
    .idx_c (arb_idx),
    .any_c (arb_any)
  );

  // Candidate selection, handshake and next-state of the output register.
  always_comb begin
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    out_valid_d   = out_valid_q;
    rr_ptr_d      = rr_ptr_q;
    cand          = '0;
    cand_oh       = '0;
    grant         = 1'b0;
    sel_data      = '0;

    load_en = !out_valid_q || out_ready;

    if (mode == MODE_RR) begin
      cand    = arb_idx;
      cand_oh = arb_gnt;
      grant   = arb_any;
    end else begin
      cand          = address;
      cand_oh[address] = 1'b1;
      grant         = in_valid[address];
    end

    // Reset also blocks the handshake so nothing is accepted while the register is cleared.
    xfer     = load_en && grant && !reset;
    in_ready = xfer ? cand_oh : '0;

    for (int i = 0; i < CHANNELS; i++) begin
      if (cand == SEL_W'(i)) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end

    if (xfer) begin
      out_data_d    = sel_data;
      out_channel_d = cand;
      out_valid_d   = 1'b1;
      if (mode == MODE_RR) begin
        rr_ptr_d = SEL_W'(cand + SEL_W'(1));
      end
    end else if (load_en) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q    <= '0;
      out_channel_q <= '0;
      out_valid_q   <= 1'b0;
      rr_ptr_q      <= '0;
    end else begin
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      out_valid_q   <= out_valid_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_channel = out_channel_q;
  assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_channel_select_mux.sv
// Bench for channel_select_mux: directed scenarios with literal expectations
// plus randomized traffic checked against a behavioural model every cycle.
module tb_channel_select_mux;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           mode = 1'b0;
  logic [1:0]     address = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_channel;
  logic           out_valid;
  logic           out_ready = 1'b0;

  always #5 clk = ~clk;

  channel_select_mux #(.WIDTH(W), .CHANNELS(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode),
    .address     (address),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_channel (out_channel),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit         m_valid = 1'b0;
  logic [7:0] m_data  = '0;
  int         m_ch    = 0;
  int         m_ptr   = 0;
  int         m_cand  = 0;
  bit         m_grant = 1'b0;
  logic [3:0] m_ready = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_comb();
    m_grant = 1'b0;
    m_cand  = 0;
    if (mode == 1'b0) begin
      m_cand  = int'(address);
      m_grant = in_valid[address];
    end else begin
      for (int k = 0; k < N; k++) begin
        int c = (m_ptr + k) % N;
        if (!m_grant && in_valid[c]) begin
          m_grant = 1'b1;
          m_cand  = c;
        end
      end
    end
    m_ready = '0;
    if ((!m_valid || out_ready) && m_grant) m_ready[m_cand] = 1'b1;
  endtask

  task automatic model_edge();
    if (!m_valid || out_ready) begin
      if (m_grant) begin
        m_valid = 1'b1;
        m_data  = in_data[m_cand*W +: W];
        m_ch    = m_cand;
        if (mode == 1'b1) m_ptr = (m_cand + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic check_outs();
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_channel", 32'(out_channel), 32'(m_ch));
    end
  endtask

  // One cycle: entered just after a negedge with inputs set, leaves at the next negedge.
  task automatic step();
    #1;
    model_comb();
    chk("in_ready", 32'(in_ready), 32'(m_ready));
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst out_valid", 32'(out_valid), 32'h0);
    chk("rst out_data", 32'(out_data), 32'h0);
    chk("rst out_channel", 32'(out_channel), 32'h0);
    chk("rst in_ready", 32'(in_ready), 32'h0);
    m_valid = 1'b0;
    m_data  = '0;
    m_ch    = 0;
    m_ptr   = 0;
    #1;
    reset = 1'b0;
  endtask

  task automatic set_ch(input int ch, input logic [7:0] d);
    in_data[ch*W +: W] = d;
  endtask

  initial begin
    int exp_rr[6];
    exp_rr = '{0, 1, 2, 3, 0, 1};

    @(negedge clk);
    do_reset();

    // Reset while a word is held
    mode = 1'b0; address = 2'd2; in_valid = 4'b0100; set_ch(2, 8'hA5); out_ready = 1'b0;
    step();
    chk("t1 loaded", 32'(out_valid), 32'h1);
    do_reset();

    // Addressed mode
    out_ready = 1'b1;
    #1 chk("t2 in_ready hit", 32'(in_ready), 32'h4);
    step();
    chk("t2 out_data", 32'(out_data), 32'hA5);
    chk("t2 out_channel", 32'(out_channel), 32'h2);
    address = 2'd1;
    #1 chk("t2 in_ready miss", 32'(in_ready), 32'h0);
    step();
    chk("t2 drained", 32'(out_valid), 32'h0);

    // Round-robin over all channels
    mode = 1'b1; in_valid = 4'b1111;
    for (int i = 0; i < N; i++) set_ch(i, 8'(8'h10 + i));
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t3 rr order", 32'(out_channel), 32'(exp_rr[i]));
    end

    // Mode switch keeps the round-robin pointer (now 2)
    mode = 1'b0; address = 2'd0;
    step(); chk("t6 addr a", 32'(out_channel), 32'h0);
    step(); chk("t6 addr b", 32'(out_channel), 32'h0);
    mode = 1'b1;
    step(); chk("t6 rr resume", 32'(out_channel), 32'h2);
    chk("t6 rr data", 32'(out_data), 32'h12);

    // Wrap-around with sparse requests, pointer starting at 1
    do_reset();
    mode = 1'b1; in_valid = 4'b0001;
    step(); chk("t4 prime", 32'(out_channel), 32'h0);
    in_valid = 4'b1001;
    step(); chk("t4 grant a", 32'(out_channel), 32'h3);
    step(); chk("t4 grant b", 32'(out_channel), 32'h0);
    step(); chk("t4 grant c", 32'(out_channel), 32'h3);

    // Backpressure then release with no bubble
    mode = 1'b0; address = 2'd1; in_valid = 4'b0010; set_ch(1, 8'h3C); out_ready = 1'b1;
    step(); chk("t5 first", 32'(out_data), 32'h3C);
    out_ready = 1'b0; set_ch(1, 8'h77);
    for (int i = 0; i < 3; i++) begin
      #1 chk("t5 stall ready", 32'(in_ready), 32'h0);
      step();
      chk("t5 stall data", 32'(out_data), 32'h3C);
      chk("t5 stall valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    #1 chk("t5 release ready", 32'(in_ready), 32'h2);
    step();
    chk("t5 next data", 32'(out_data), 32'h77);
    chk("t5 next valid", 32'(out_valid), 32'h1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      mode      = 1'($urandom_range(0, 1));
      address   = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom);
      in_data   = 32'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
